// File: rtl/req_queue_pkg.sv
// req_queue_pkg: shared widths, stat type and pointer-width helper for req_queue.
package req_queue_pkg;
  localparam int STAT_W = 16;
  typedef logic [STAT_W-1:0] stat_t;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/req_sat_counter.sv
// req_sat_counter: enabled up-counter that sticks at all-ones instead of wrapping.
module req_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_en && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/req_queue.sv
// req_queue: registered DEPTH-entry FIFO of 1-bit requests between arbiter and consumer.
// Define REQ_QUEUE_STATS_EN to add dequeued-value counters and an overflow-enqueue assertion.
module req_queue
  import req_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  in_a__ENA,
  input  logic  in_a_v,
  output logic  in_a__RDY,
  output logic  out_a__ENA,
  output logic  out_a_v,
  input  logic  out_a__RDY
`ifdef REQ_QUEUE_STATS_EN
  ,
  output stat_t stat_ones,
  output stat_t stat_zeros
`endif
);
  localparam int PW = ptr_w(DEPTH);
  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wp, r_rp;
  logic [PW:0]      r_cnt;
  logic             w_full, w_empty, w_enq, w_deq;
  assign w_full     = r_cnt == (PW+1)'(DEPTH);
  assign w_empty    = r_cnt == '0;
  assign w_enq      = in_a__ENA && !w_full;
  assign w_deq      = out_a__ENA;
  assign in_a__RDY  = !w_full;
  assign out_a__ENA = !w_empty && out_a__RDY;
  assign out_a_v    = !w_empty && r_mem[r_rp];
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_enq) r_wp <= r_wp + 1'b1;
      if (w_deq) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(w_enq) - (PW+1)'(w_deq);
    end
  // Contents need no reset: the output is masked while empty.
  always_ff @(posedge CLK)
    if (w_enq) r_mem[r_wp] <= in_a_v;
`ifdef REQ_QUEUE_STATS_EN
  req_sat_counter #(.W(STAT_W)) u_ones (
    .i_clk(CLK), .i_rst_n(nRST), .i_en(out_a__ENA && out_a_v), .o_cnt(stat_ones)
  );
  req_sat_counter #(.W(STAT_W)) u_zeros (
    .i_clk(CLK), .i_rst_n(nRST), .i_en(out_a__ENA && !out_a_v), .o_cnt(stat_zeros)
  );
  a_no_overflow: assert property (@(posedge CLK) disable iff (!nRST) !(in_a__ENA && w_full))
    else $error("enqueue while full");
`endif
endmodule

// File: tb/tb_req_queue.sv
// tb_req_queue: scoreboard-driven bench for req_queue (DEPTH=4); stats test needs REQ_QUEUE_STATS_EN.
module tb_req_queue;
  import req_queue_pkg::*;
  logic clk = 0, rst_n = 0;
  logic in_ena = 0, in_v = 0, in_rdy, out_ena, out_v, out_rdy = 0;
`ifdef REQ_QUEUE_STATS_EN
  stat_t st_ones, st_zeros;
`endif
  int errors = 0, checks = 0, deq_cnt = 0;
  bit sb[$];

  req_queue #(.DEPTH(4)) dut (
    .CLK(clk), .nRST(rst_n),
    .in_a__ENA(in_ena), .in_a_v(in_v), .in_a__RDY(in_rdy),
    .out_a__ENA(out_ena), .out_a_v(out_v), .out_a__RDY(out_rdy)
`ifdef REQ_QUEUE_STATS_EN
    , .stat_ones(st_ones), .stat_zeros(st_zeros)
`endif
  );

  always #5 clk = ~clk;

  // Every dequeue the DUT performs is matched against the oldest expected entry.
  always @(negedge clk)
    if (rst_n && out_ena) begin
      checks++;
      deq_cnt++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL deq_unexpected: got value %0b, expected no dequeue", out_v);
      end else begin
        bit e;
        e = sb.pop_front();
        if (out_v !== e) begin
          errors++;
          $display("FAIL deq_order: got %0b, expected %0b", out_v, e);
        end
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input bit v);
    in_ena = 1;
    in_v = v;
    sb.push_back(v);
  endtask

  task automatic drain();
    out_rdy = 1;
    in_ena = 0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    step();
    @(negedge clk);
    checks++;
    if (sb.size() != 0 || out_ena !== 1'b0) begin
      errors++;
      $display("FAIL drain: left=%0d out_ena=%0b, expected 0/0", sb.size(), out_ena);
    end
  endtask

  task automatic test_reset();
    out_rdy = 1;
    #12;
    checks++;
    if (in_rdy !== 1'b1 || out_ena !== 1'b0 || out_v !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b ena=%0b v=%0b, expected 1/0/0", in_rdy, out_ena, out_v);
    end
    step();
    rst_n = 1;
    step();
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b1 || out_ena !== 1'b0 || out_v !== 1'b0) begin
      errors++;
      $display("FAIL idle_state: rdy=%0b ena=%0b v=%0b, expected 1/0/0", in_rdy, out_ena, out_v);
    end
`ifdef REQ_QUEUE_STATS_EN
    checks++;
    if (st_ones !== 16'd0 || st_zeros !== 16'd0) begin
      errors++;
      $display("FAIL stats_reset: ones=%0d zeros=%0d, expected 0/0", st_ones, st_zeros);
    end
`endif
  endtask

  task automatic test_stream();
    int vals[3] = '{1, 0, 1};
    out_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) enq(vals[i][0]);
      else in_ena = 0;
      @(negedge clk);
      checks++;
      if (out_ena !== (i != 0)) begin
        errors++;
        $display("FAIL stream_ena[%0d]: got %0b, expected %0b", i, out_ena, i != 0);
      end
    end
    step();
    @(negedge clk);
    checks++;
    if (out_ena !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL stream_empty: ena=%0b left=%0d, expected 0/0", out_ena, sb.size());
    end
  endtask

  task automatic test_full();
    out_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      enq(1'($urandom_range(0, 1)));
    end
    step();
    in_ena = 0;
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b0 || out_ena !== 1'b0) begin
      errors++;
      $display("FAIL full_rdy: rdy=%0b ena=%0b, expected 0/0", in_rdy, out_ena);
    end
    step();
    out_rdy = 1;
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b0 || out_ena !== 1'b1) begin
      errors++;
      $display("FAIL full_deq_same_cycle: rdy=%0b ena=%0b, expected 0/1", in_rdy, out_ena);
    end
    step();
    out_rdy = 0;
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b1 || out_ena !== 1'b0 || sb.size() != 3) begin
      errors++;
      $display("FAIL full_after_deq: rdy=%0b ena=%0b left=%0d, expected 1/0/3", in_rdy, out_ena, sb.size());
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int left = 12, d0;
    out_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      enq(1'($urandom_range(0, 1)));
    end
    step();
    in_ena = 0;
    out_rdy = 1;
    d0 = deq_cnt;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) step();
      in_ena = 0;
      if (left > 0 && in_rdy) begin
        enq(1'($urandom_range(0, 1)));
        left--;
      end
      @(negedge clk);
      checks++;
      if (out_ena !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ena[%0d]: got %0b, expected 1", c, out_ena);
      end
    end
    step();
    in_ena = 0;
    @(negedge clk);
    checks++;
    if (deq_cnt - d0 != 16 || left != 0 || out_ena !== 1'b0) begin
      errors++;
      $display("FAIL b2b_total: deq=%0d unsent=%0d ena=%0b, expected 16/0/0", deq_cnt - d0, left, out_ena);
    end
  endtask

  task automatic test_reset_mid();
    out_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      enq(1'b1);
    end
    step();
    in_ena = 0;
    out_rdy = 1;
    #1;
    rst_n = 0;
    sb.delete();
    #1;
    checks++;
    if (out_ena !== 1'b0 || in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: ena=%0b rdy=%0b, expected 0/1", out_ena, in_rdy);
    end
    step();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (out_ena !== 1'b0) begin
        errors++;
        $display("FAIL stale_entry[%0d]: ena=%0b, expected 0", i, out_ena);
      end
    end
  endtask

`ifdef REQ_QUEUE_STATS_EN
  task automatic test_stats();
    step();
    rst_n = 0;
    sb.delete();
    step();
    rst_n = 1;
    out_rdy = 1;
    for (int i = 0; i < 65535; i++) begin
      step();
      enq(1'b1);
    end
    step();
    in_ena = 0;
    step();
    @(negedge clk);
    checks++;
    if (st_ones !== 16'hFFFF || st_zeros !== 16'd0) begin
      errors++;
      $display("FAIL stats_preload: ones=%h zeros=%h, expected ffff/0000", st_ones, st_zeros);
    end
    step();
    enq(1'b1);
    step();
    enq(1'b0);
    step();
    in_ena = 0;
    step();
    @(negedge clk);
    checks++;
    if (st_ones !== 16'hFFFF || st_zeros !== 16'd1) begin
      errors++;
      $display("FAIL stats_saturate: ones=%h zeros=%h, expected ffff/0001", st_ones, st_zeros);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_back_to_back();
    test_reset_mid();
`ifdef REQ_QUEUE_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/req_queue.md
# req_queue

Registered request queue directly downstream of the two-source request arbiter. Accepts the arbiter's single merged 1-bit request stream through a method-style enable/ready handshake and buffers up to DEPTH requests. Replays them in order to the next consumer through an identical outgoing callout. It decouples the arbiter's guard from the consumer's back-pressure, so the arbiter's ready no longer depends combinationally on the consumer.

## Interface
- DEPTH, 4, queue capacity in entries; power of two, at least 2.
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- in$a__ENA  input  1  enqueue strobe from the arbiter; asserted only while in$a__RDY is high.
- in$a$v  input  1  request value, valid while in$a__ENA is high.
- in$a__RDY  output  1  queue can accept; equals !full.
- out$a__ENA  output  1  dequeue call to the consumer.
- out$a$v  output  1  head-entry value.
- out$a__RDY  input  1  consumer can accept.
- stat$ones / stat$zeros  output  16  dequeued-value counters; present only with REQ_QUEUE_STATS_EN.

## Operation
- Storage:
  - DEPTH x 1-bit register array.
  - Write and read pointers, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy count, log2(DEPTH)+1 bits.
- Reset:
  - Pointers and count go to 0.
  - in$a__RDY goes to 1.
  - out$a__ENA goes to 0.
  - out$a$v goes to 0 (array contents are don't-care, but the output is masked to 0 while empty).
  - Stats counters go to 0.
- Enqueue:
  - When in$a__ENA is high, write in$a$v at the write pointer and increment the write pointer.
  - An enqueue while full is a protocol violation. The queue must ignore it (no write, no pointer move). With the stats macro enabled, it is also flagged by an assertion.
- Dequeue:
  - out$a__ENA = !empty && out$a__RDY, combinational.
  - When out$a__ENA is high, increment the read pointer.
- Count:
  - count += enq - deq.
  - A simultaneous enqueue and dequeue leaves the count unchanged and moves both pointers.
- Full and empty:
  - full = (count == DEPTH); empty = (count == 0).
  - When full, the queue has no same-cycle pass-through: in$a__RDY stays low even if a dequeue occurs that cycle.
  - When empty, the queue has no bypass: a request enqueued in cycle N is first visible on out$a__ENA in cycle N+1.
- Reset mid-operation: all queued requests are discarded immediately (asynchronous). No out$a__ENA is issued in the reset cycle.

## Timing
- Latency from enqueue to earliest dequeue: 1 cycle.
- Sustained throughput: 1 request per cycle when the consumer is always ready.
- in$a__RDY is a registered-state decode with no combinational path from any input.
- out$a__ENA has exactly one combinational input path, from out$a__RDY.
- out$a$v depends only on registered state.

## Configuration
- REQ_QUEUE_STATS_EN defined:
  - stat$ones and stat$zeros ports exist.
  - Each counter increments on a dequeue carrying value 1 or 0 respectively.
  - Each saturates at 16'hFFFF and does not wrap.
  - An overflow-enqueue assertion is enabled.
- REQ_QUEUE_STATS_EN undefined: the ports, counters and assertion are absent. Queue behaviour is identical in both cases.

## Structure
- Shared package req_queue_pkg holds:
  - localparam STAT_W = 16.
  - A function computing the pointer width from DEPTH.
  - typedef stat_t (logic [STAT_W-1:0]).
- One sub-module, req_sat_counter: a saturating counter with enable, async active-low reset, parameterised width. It is instantiated twice under REQ_QUEUE_STATS_EN.
- Pointer and array logic stay in req_queue.

## Test plan
- Reset then idle → in$a__RDY=1, out$a__ENA=0, out$a$v=0. Stats read 0/0.
- Consumer ready; enqueue 1,0,1 in consecutive cycles starting at cycle N → out$a__ENA high in cycles N+1..N+3 with values 1,0,1. Queue empty afterwards.
- DEPTH=4, consumer not ready; enqueue 4 values → in$a__RDY=0 after the 4th. Raise out$a__RDY for one cycle → 1 dequeue, in$a__RDY=1 the next cycle, not the same cycle.
- Full queue, consumer ready every cycle, enqueue every cycle → 1/cycle throughput; pointers wrap past 3→0 with FIFO order preserved over 12 entries.
- Assert nRST low while holding 3 entries → out$a__ENA=0 and in$a__RDY=1 asynchronously; after release, no stale entries are dequeued.
- REQ_QUEUE_STATS_EN, stat$ones preloaded via 65535 dequeues of value 1 → another dequeue of 1 keeps it at 16'hFFFF; a dequeue of 0 increments stat$zeros to 1.
